// File: rtl/cpu_ctrl_pkg.sv
// Shared definitions for the CPU decode-stage sequencing control unit:
// opcode map, FSM state encoding, datapath control bundle and the
// opcode-to-datapath-control decode function.
package cpu_ctrl_pkg;

  // ALU group 00-07
  localparam logic [4:0] OPC_AND  = 5'h00;
  localparam logic [4:0] OPC_OR   = 5'h01;
  localparam logic [4:0] OPC_XOR  = 5'h02;
  localparam logic [4:0] OPC_NOT  = 5'h03;
  localparam logic [4:0] OPC_ADD  = 5'h04;
  localparam logic [4:0] OPC_LSL  = 5'h05;
  localparam logic [4:0] OPC_SR   = 5'h06;
  localparam logic [4:0] OPC_ROT  = 5'h07;
  // Moves, memory and control flow
  localparam logic [4:0] OPC_MOV  = 5'h08;
  localparam logic [4:0] OPC_LDR  = 5'h09;
  localparam logic [4:0] OPC_LDU  = 5'h0A;
  localparam logic [4:0] OPC_LDL  = 5'h0B;
  localparam logic [4:0] OPC_ST   = 5'h0C;
  localparam logic [4:0] OPC_J    = 5'h0D;
  localparam logic [4:0] OPC_B    = 5'h0E;
  localparam logic [4:0] OPC_NOP  = 5'h0F;
  localparam logic [4:0] OPC_HALT = 5'h1F;
  // Everything from here up to (but excluding) HALT is a VPU instruction
  localparam logic [4:0] OPC_VPU_LO = 5'h10;

  typedef enum logic [1:0] {
    ST_RUN      = 2'd0,
    ST_WAIT     = 2'd1,
    ST_VPU_WAIT = 2'd2,
    ST_HALTED   = 2'd3
  } ctrl_state_e;

  typedef struct packed {
    logic alu_to_reg;
    logic pcr_to_reg;
    logic mem_to_reg;
    logic reg_we_dst_0;
    logic reg_we_dst_1;
    logic mem_we;
    logic mem_re;
    logic add_immd;
    logic jump_immd;
    logic ldu;
    logic ldl;
    logic branch;
    logic jump;
    logic z_we;
    logic n_we;
    logic v_we;
  } dp_ctrl_t;

  function automatic logic is_vpu_op(input logic [4:0] opc);
    return (opc >= OPC_VPU_LO) && (opc != OPC_HALT);
  endfunction

  // Raw datapath controls for an opcode; gating by valid/stall is the caller's job.
  // Flag write enables are never driven by this decoder.
  function automatic dp_ctrl_t decode_dp(input logic [4:0] opc, input logic xb);
    dp_ctrl_t c;
    c = '0;
    case (opc)
      OPC_AND, OPC_OR, OPC_XOR, OPC_NOT, OPC_ADD, OPC_LSL, OPC_SR, OPC_ROT: begin
        c.alu_to_reg   = 1'b1;
        c.reg_we_dst_0 = 1'b1;
        c.add_immd     = (opc == OPC_ADD) && xb;
      end
      OPC_MOV: begin
        c.reg_we_dst_0 = 1'b1;
        c.reg_we_dst_1 = 1'b1;
      end
      OPC_LDR: begin
        c.mem_re       = 1'b1;
        c.mem_to_reg   = 1'b1;
        c.reg_we_dst_0 = 1'b1;
      end
      OPC_LDU: begin
        c.reg_we_dst_0 = 1'b1;
        c.ldu          = 1'b1;
      end
      OPC_LDL: begin
        c.reg_we_dst_0 = 1'b1;
        c.ldl          = 1'b1;
      end
      OPC_ST: c.mem_we = 1'b1;
      OPC_J: begin
        c.jump         = 1'b1;
        c.pcr_to_reg   = 1'b1;
        c.reg_we_dst_1 = 1'b1;
        c.jump_immd    = xb;
      end
      OPC_B: c.branch = 1'b1;
      default: ;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/cpu_ctrl_seq_if.sv
// Decode-stage bundle between the fetch/decode register, the sequencing
// control unit and the datapath/VPU channels. The control unit is the slave.
interface cpu_ctrl_seq_if #(
  parameter int NUM_VPU = 2,
  parameter int TIMER_W = 11
);
  localparam int VSEL_W = (NUM_VPU > 1) ? $clog2(NUM_VPU) : 1;

  // Instruction side and VPU status
  logic               instr_valid;
  logic [4:0]         opcode;
  logic               x_bit;
  logic [TIMER_W-1:0] wait_time;
  logic [VSEL_W-1:0]  vpu_sel;
  logic [NUM_VPU-1:0] vpu_rdy;
  logic [NUM_VPU-1:0] vpu_done;
  logic               resume;

  // Sequencing and datapath controls
  logic               stall;
  logic [NUM_VPU-1:0] vpu_start;
  logic               alu_to_reg;
  logic               pcr_to_reg;
  logic               mem_to_reg;
  logic               reg_we_dst_0;
  logic               reg_we_dst_1;
  logic               mem_we;
  logic               mem_re;
  logic               add_immd;
  logic               jump_immd;
  logic               ldu;
  logic               ldl;
  logic               branch;
  logic               jump;
  logic               z_we;
  logic               n_we;
  logic               v_we;
  logic               halted;
  logic               illegal_op;
  logic [31:0]        perf_stall_cnt;

  modport master (
    output instr_valid, opcode, x_bit, wait_time, vpu_sel, vpu_rdy, vpu_done, resume,
    input  stall, vpu_start, alu_to_reg, pcr_to_reg, mem_to_reg, reg_we_dst_0,
           reg_we_dst_1, mem_we, mem_re, add_immd, jump_immd, ldu, ldl, branch, jump,
           z_we, n_we, v_we, halted, illegal_op, perf_stall_cnt
  );

  modport slave (
    input  instr_valid, opcode, x_bit, wait_time, vpu_sel, vpu_rdy, vpu_done, resume,
    output stall, vpu_start, alu_to_reg, pcr_to_reg, mem_to_reg, reg_we_dst_0,
           reg_we_dst_1, mem_we, mem_re, add_immd, jump_immd, ldu, ldl, branch, jump,
           z_we, n_we, v_we, halted, illegal_op, perf_stall_cnt
  );

endinterface

// File: rtl/cpu_ctrl_seq_wait_timer.sv
// NOP/WAIT countdown. Loaded with the wait count, decrements to zero;
// 'last' flags the final wait cycle so the FSM can leave WAIT on time.
module ctrl_wait_timer #(
  parameter int TIMER_W = 11
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               load,
  input  logic [TIMER_W-1:0] value,
  output logic               last,
  output logic               busy
);

  logic [TIMER_W-1:0] timer_q, timer_d;

  // Next count: load wins, otherwise count down until zero
  always_comb begin
    // NOTE: default assignment first so every path writes timer_d and no latch is inferred.
    timer_d = timer_q;
    if (load) begin
      timer_d = value;
    end else if (timer_q != '0) begin
      timer_d = timer_q - TIMER_W'(1);
    end
  end

  // Count register, cleared by synchronous reset
  always_ff @(posedge clk) begin
    // NOTE: state updates use non-blocking assignments so all flops sample pre-edge values.
    if (rst) begin
      timer_q <= '0;
    end else begin
      timer_q <= timer_d;
    end
  end

  assign busy = (timer_q != '0);
  assign last = (timer_q == TIMER_W'(1));

endmodule

// File: rtl/cpu_ctrl_seq.sv
// Decode-stage sequencing control unit: decodes opcode/x_bit into datapath
// controls and owns all decode stalls (NOP/WAIT timer, VPU start/done
// handshake over NUM_VPU channels, resumable HALT).
// Optional feature: define CTRL_PERF_CNT_EN to build a saturating 32-bit
// stall-cycle counter on perf_stall_cnt; otherwise that output is tied to 0.
module cpu_ctrl_seq
  import cpu_ctrl_pkg::*;
#(
  parameter int NUM_VPU = 2,
  parameter int TIMER_W = 11
) (
  input  logic          clk,
  input  logic          rst,
  cpu_ctrl_seq_if.slave ifc
);

  localparam int VSEL_W = (NUM_VPU > 1) ? $clog2(NUM_VPU) : 1;

  ctrl_state_e       state_q, state_d;
  logic [VSEL_W-1:0] sel_q, sel_d;

  logic     run;
  logic     vpu_op;
  logic     nop_op;
  logic     halt_op;
  logic     sel_legal;
  logic     rdy_sel;
  logic     done_sel;
  logic     stall;
  logic     fire;
  logic     timer_load;
  logic     timer_last;
  logic     timer_busy;
  dp_ctrl_t dp;

  // Instruction classification, channel lookup, stall and datapath gating
  always_comb begin
    run       = (state_q == ST_RUN);
    vpu_op    = ifc.instr_valid && is_vpu_op(ifc.opcode);
    nop_op    = ifc.instr_valid && (ifc.opcode == OPC_NOP);
    halt_op   = ifc.instr_valid && (ifc.opcode == OPC_HALT);
    sel_legal = 1'b0;
    rdy_sel   = 1'b0;
    done_sel  = 1'b0;
    // Channel numbers >= NUM_VPU match no entry and therefore read as illegal
    for (int i = 0; i < NUM_VPU; i++) begin
      if (ifc.vpu_sel == VSEL_W'(i)) begin
        sel_legal = 1'b1;
        rdy_sel   = ifc.vpu_rdy[i];
      end
      if (sel_q == VSEL_W'(i)) begin
        done_sel = ifc.vpu_done[i];
      end
    end
    stall      = !run || (vpu_op && sel_legal && !rdy_sel);
    fire       = run && vpu_op && sel_legal && rdy_sel;
    timer_load = run && nop_op && (ifc.wait_time != '0);
    dp         = (run && ifc.instr_valid && !stall) ? decode_dp(ifc.opcode, ifc.x_bit) : '0;
  end

  // Next-state logic; sel is latched only when a blocking VPU op is started
  always_comb begin
    state_d = state_q;
    sel_d   = sel_q;
    case (state_q)
      ST_RUN: begin
        if (timer_load) begin
          state_d = ST_WAIT;
        end else if (halt_op) begin
          state_d = ST_HALTED;
        end else if (fire && !ifc.x_bit) begin
          state_d = ST_VPU_WAIT;
          sel_d   = ifc.vpu_sel;
        end
      end
      ST_WAIT: begin
        if (timer_last || !timer_busy) state_d = ST_RUN;
      end
      ST_VPU_WAIT: begin
        if (done_sel) state_d = ST_RUN;
      end
      ST_HALTED: begin
        if (ifc.resume) state_d = ST_RUN;
      end
      default: state_d = ST_RUN;
    endcase
  end

  // FSM state and latched VPU channel; reset beats resume and aborts any wait
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_RUN;
      sel_q   <= '0;
    end else begin
      state_q <= state_d;
      sel_q   <= sel_d;
    end
  end

  ctrl_wait_timer #(
    .TIMER_W(TIMER_W)
  ) u_wait_timer (
    .clk  (clk),
    .rst  (rst),
    .load (timer_load),
    .value(ifc.wait_time),
    .last (timer_last),
    .busy (timer_busy)
  );

  // One-hot start pulse on the selected channel in the first ready cycle
  always_comb begin
    ifc.vpu_start = '0;
    for (int i = 0; i < NUM_VPU; i++) begin
      if (fire && (ifc.vpu_sel == VSEL_W'(i))) ifc.vpu_start[i] = 1'b1;
    end
  end

  assign ifc.stall        = stall;
  assign ifc.halted       = (state_q == ST_HALTED);
  assign ifc.illegal_op   = run && vpu_op && !sel_legal;
  assign ifc.alu_to_reg   = dp.alu_to_reg;
  assign ifc.pcr_to_reg   = dp.pcr_to_reg;
  assign ifc.mem_to_reg   = dp.mem_to_reg;
  assign ifc.reg_we_dst_0 = dp.reg_we_dst_0;
  assign ifc.reg_we_dst_1 = dp.reg_we_dst_1;
  assign ifc.mem_we       = dp.mem_we;
  assign ifc.mem_re       = dp.mem_re;
  assign ifc.add_immd     = dp.add_immd;
  assign ifc.jump_immd    = dp.jump_immd;
  assign ifc.ldu          = dp.ldu;
  assign ifc.ldl          = dp.ldl;
  assign ifc.branch       = dp.branch;
  assign ifc.jump         = dp.jump;
  assign ifc.z_we         = dp.z_we;
  assign ifc.n_we         = dp.n_we;
  assign ifc.v_we         = dp.v_we;

`ifdef CTRL_PERF_CNT_EN
  logic [31:0] perf_q, perf_d;

  // Saturating stall-cycle count
  always_comb begin
    perf_d = perf_q;
    if (stall && (perf_q != 32'hFFFF_FFFF)) perf_d = perf_q + 32'd1;
  end

  // Counter register, cleared by reset
  always_ff @(posedge clk) begin
    if (rst) begin
      perf_q <= '0;
    end else begin
      perf_q <= perf_d;
    end
  end

  assign ifc.perf_stall_cnt = perf_q;
`else
  assign ifc.perf_stall_cnt = '0;
`endif

endmodule
